// File: rtl/uart_tx_frame.sv
// uart_tx_frame -- UART transmitter framing one word per request.
//
// Frame: start (0), DataBits payload bits LSB first, optional parity bit,
// StopBits stop bits (1). Every bit lasts BitCycles = ClockFrequency/BaudRate
// clocks. All outputs are registered.
//
// Ports:
//   clock             rising-edge clock
//   reset             asynchronous active-low reset
//   startTransmission frame request, sampled in IDLE
//   data              payload, latched when the request is accepted
//   sendBreak         (UART_TX_FRAME_BREAK_EN only) hold line low while idle
//   busy              high while a frame (or break) is in progress
//   done              one-cycle pulse in the cycle after the last stop bit
//   tx                serial line, idle high
//
// Optional feature macro: UART_TX_FRAME_BREAK_EN (adds sendBreak).
module uart_tx_frame #(
   parameter int ClockFrequency = 1000000,
   parameter int BaudRate       = 9600,
   parameter int DataBits       = 8,
   parameter int ParityMode     = 0,   // 0 none, 1 odd, 2 even
   parameter int StopBits       = 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                startTransmission,
   input  logic [DataBits-1:0] data,
`ifdef UART_TX_FRAME_BREAK_EN
   input  logic                sendBreak,
`endif
   output logic                busy,
   output logic                done,
   output logic                tx
);
   localparam int BitCycles = ClockFrequency / BaudRate;
   // Sized for the 2-stop-bit STOP state, which counts 2*BitCycles-1.
   localparam int CntW = $clog2(2 * BitCycles);
   localparam int IdxW = $clog2(DataBits);
   localparam logic [CntW-1:0] BitLast  = CntW'(BitCycles - 1);
   localparam logic [CntW-1:0] StopLast = CntW'(StopBits * BitCycles - 1);
   localparam logic [IdxW-1:0] IdxLast  = IdxW'(DataBits - 1);

   if (ClockFrequency < 2 * BaudRate) begin : g_bad_baud
      $error("uart_tx_frame: ClockFrequency must be at least 2*BaudRate");
   end
   if (DataBits < 5 || DataBits > 9) begin : g_bad_bits
      $error("uart_tx_frame: DataBits must be 5..9");
   end
   if (ParityMode < 0 || ParityMode > 2) begin : g_bad_par
      $error("uart_tx_frame: ParityMode must be 0, 1 or 2");
   end
   if (StopBits < 1 || StopBits > 2) begin : g_bad_stop
      $error("uart_tx_frame: StopBits must be 1 or 2");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t              state, state_n;
   logic [CntW-1:0]     cnt, cnt_n;
   logic [IdxW-1:0]     idx, idx_n;
   logic [DataBits-1:0] shreg, shreg_n;
   logic                par, par_n;
   logic                tx_n, busy_n, done_n;
   logic                brk;

`ifdef UART_TX_FRAME_BREAK_EN
   assign brk = sendBreak;
`else
   assign brk = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
         par   <= 1'b0;
         tx    <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         shreg <= shreg_n;
         par   <= par_n;
         tx    <= tx_n;
         busy  <= busy_n;
         done  <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      idx_n   = idx;
      shreg_n = shreg;
      par_n   = par;
      done_n  = 1'b0;
      tx_n    = 1'b1;
      busy_n  = 1'b0;

      case (state)
         IDLE: begin
            cnt_n = '0;
            if (startTransmission && !brk) begin
               state_n = START;
               shreg_n = data;
               idx_n   = '0;
               par_n   = (ParityMode == 1) ? ~^data : ^data;
            end
         end
         START: begin
            if (cnt == BitLast) begin
               state_n = DATA;
               cnt_n   = '0;
            end
         end
         DATA: begin
            if (cnt == BitLast) begin
               cnt_n = '0;
               if (idx == IdxLast) begin
                  state_n = (ParityMode != 0) ? PARITY : STOP;
               end else begin
                  idx_n   = idx + 1'b1;
                  shreg_n = shreg >> 1;
               end
            end
         end
         PARITY: begin
            if (cnt == BitLast) begin
               state_n = STOP;
               cnt_n   = '0;
            end
         end
         STOP: begin
            if (cnt == StopLast) begin
               state_n = IDLE;
               cnt_n   = '0;
               done_n  = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase

      // Registered line value for the state being entered; DATA always
      // presents bit 0 of the (possibly just shifted) register.
      case (state_n)
         START:   begin tx_n = 1'b0;       busy_n = 1'b1; end
         DATA:    begin tx_n = shreg_n[0]; busy_n = 1'b1; end
         PARITY:  begin tx_n = par_n;      busy_n = 1'b1; end
         STOP:    begin tx_n = 1'b1;       busy_n = 1'b1; end
         default: begin tx_n = 1'b1;       busy_n = 1'b0; end
      endcase

      // Break only applies from a settled IDLE, never to the done cycle.
      if (state == IDLE && brk) begin
         tx_n   = 1'b0;
         busy_n = 1'b1;
      end
   end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame -- directed checks of uart_tx_frame framing, parity,
// back-to-back requests, mid-frame reset, ignored mid-frame requests and,
// when UART_TX_FRAME_BREAK_EN is defined, the break feature.
// All instances run at BitCycles = 10.
module tb_uart_tx_frame;
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   // 8N1 instance
   logic s8n = 1'b0;
   logic [7:0] d8n = '0;
   logic b8n, dn8n, t8n;
   // 8E1 / 8O1 instances share a request
   logic s8p = 1'b0;
   logic [7:0] d8p = '0;
   logic b8e, dn8e, t8e, b8o, dn8o, t8o;
   // 7N2 instance
   logic s7 = 1'b0;
   logic [6:0] d7 = '0;
   logic b7, dn7, t7;
`ifdef UART_TX_FRAME_BREAK_EN
   logic sb = 1'b0;
`endif

   uart_tx_frame #(.ClockFrequency(1000000), .BaudRate(100000), .DataBits(8),
                   .ParityMode(0), .StopBits(1)) u8n (
      .clock(clock), .reset(reset), .startTransmission(s8n), .data(d8n),
`ifdef UART_TX_FRAME_BREAK_EN
      .sendBreak(sb),
`endif
      .busy(b8n), .done(dn8n), .tx(t8n));

   uart_tx_frame #(.ClockFrequency(1000000), .BaudRate(100000), .DataBits(8),
                   .ParityMode(2), .StopBits(1)) u8e (
      .clock(clock), .reset(reset), .startTransmission(s8p), .data(d8p),
`ifdef UART_TX_FRAME_BREAK_EN
      .sendBreak(1'b0),
`endif
      .busy(b8e), .done(dn8e), .tx(t8e));

   uart_tx_frame #(.ClockFrequency(1000000), .BaudRate(100000), .DataBits(8),
                   .ParityMode(1), .StopBits(1)) u8o (
      .clock(clock), .reset(reset), .startTransmission(s8p), .data(d8p),
`ifdef UART_TX_FRAME_BREAK_EN
      .sendBreak(1'b0),
`endif
      .busy(b8o), .done(dn8o), .tx(t8o));

   uart_tx_frame #(.ClockFrequency(1000000), .BaudRate(100000), .DataBits(7),
                   .ParityMode(0), .StopBits(2)) u7 (
      .clock(clock), .reset(reset), .startTransmission(s7), .data(d7),
`ifdef UART_TX_FRAME_BREAK_EN
      .sendBreak(1'b0),
`endif
      .busy(b7), .done(dn7), .tx(t7));

   int errors = 0;
   int checks = 0;
   int dcnt;

   // Hand-derived line patterns, index = bit number (0 = start bit).
   logic [9:0]  exp_a5  = 10'b1101001010;   // 8N1 0xA5
   logic [9:0]  exp_5a  = 10'b1010110100;   // 8N1 0x5A
   logic [10:0] exp_e07 = 11'b11000001110;  // 8E1 0x07, parity 1
   logic [10:0] exp_o07 = 11'b10000001110;  // 8O1 0x07, parity 0
   logic [9:0]  exp_55  = 10'b1110101010;   // 7N2 0x55
   logic [9:0]  exp_0c  = 10'b1100011000;   // 7N2 0x0C

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      // Reset state ({busy,done,tx} = 001 everywhere)
      cyc(3);
      chk("rst_8n", {b8n, dn8n, t8n}, 3'b001);
      chk("rst_8e", {b8e, dn8e, t8e}, 3'b001);
      chk("rst_8o", {b8o, dn8o, t8o}, 3'b001);
      chk("rst_7",  {b7, dn7, t7},    3'b001);
      reset = 1'b1;
      cyc(2);
      chk("idle_8n", {b8n, dn8n, t8n}, 3'b001);

      // 8N1 0xA5, one-cycle request; done 100 clocks after the start edge
      s8n = 1'b1; d8n = 8'hA5;
      cyc(1);
      s8n = 1'b0;
      for (int c = 0; c < 100; c++) begin
         chk("a5_bit", {b8n, dn8n, t8n}, {2'b10, exp_a5[c/10]});
         cyc(1);
      end
      chk("a5_done", {b8n, dn8n, t8n}, 3'b011);
      cyc(1);
      chk("a5_after", {b8n, dn8n, t8n}, 3'b001);

      // Even and odd parity on 0x07, 110-clock frame
      s8p = 1'b1; d8p = 8'h07;
      cyc(1);
      s8p = 1'b0;
      for (int c = 0; c < 110; c++) begin
         chk("par_e_bit", {b8e, dn8e, t8e}, {2'b10, exp_e07[c/10]});
         chk("par_o_bit", {b8o, dn8o, t8o}, {2'b10, exp_o07[c/10]});
         cyc(1);
      end
      chk("par_e_done", {b8e, dn8e, t8e}, 3'b011);
      chk("par_o_done", {b8o, dn8o, t8o}, 3'b011);

      // 7N2 back-to-back: second request in the done cycle
      s7 = 1'b1; d7 = 7'h55;
      cyc(1);
      s7 = 1'b0;
      for (int c = 0; c < 100; c++) begin
         chk("b2b_f1_bit", {b7, dn7, t7}, {2'b10, exp_55[c/10]});
         cyc(1);
      end
      chk("b2b_f1_done", {b7, dn7, t7}, 3'b011);
      s7 = 1'b1; d7 = 7'h0C;
      cyc(1);
      s7 = 1'b0;
      for (int c = 0; c < 100; c++) begin
         chk("b2b_f2_bit", {b7, dn7, t7}, {2'b10, exp_0c[c/10]});
         cyc(1);
      end
      chk("b2b_f2_done", {b7, dn7, t7}, 3'b011);
      cyc(1);
      chk("b2b_after", {b7, dn7, t7}, 3'b001);

      // Reset pulse at clock 35 of a frame, then an immediate new request
      s8n = 1'b1; d8n = 8'hA5;
      cyc(1);
      s8n = 1'b0;
      cyc(35);
      chk("rst_mid_busy", {b8n, dn8n}, 2'b10);
      #2 reset = 1'b0;
      #1 chk("rst_mid_abort", {b8n, dn8n, t8n}, 3'b001);
      #2 reset = 1'b1;
      s8n = 1'b1; d8n = 8'h5A;
      cyc(1);
      s8n = 1'b0;
      for (int c = 0; c < 100; c++) begin
         chk("rst_new_bit", {b8n, dn8n, t8n}, {2'b10, exp_5a[c/10]});
         cyc(1);
      end
      chk("rst_new_done", {b8n, dn8n, t8n}, 3'b011);
      cyc(1);

      // Re-requests and data changes mid-frame are ignored; one done pulse
      s8n = 1'b1; d8n = 8'hA5;
      cyc(1);
      s8n = 1'b0;
      dcnt = 0;
      for (int c = 0; c < 100; c++) begin
         if (c == 30) begin s8n = 1'b1; d8n = 8'hFF; end
         if (c == 40) begin s8n = 1'b0; d8n = 8'h00; end
         chk("ign_bit", {b8n, dn8n, t8n}, {2'b10, exp_a5[c/10]});
         cyc(1);
      end
      for (int c = 0; c < 20; c++) begin
         if (dn8n) dcnt++;
         cyc(1);
      end
      chk("ign_done_count", dcnt, 1);
      chk("ign_idle", {b8n, dn8n, t8n}, 3'b001);

`ifdef UART_TX_FRAME_BREAK_EN
      // Break held for 50 clocks in IDLE; a request during it is dropped
      sb = 1'b1;
      cyc(1);
      for (int c = 0; c < 50; c++) begin
         if (c == 10) s8n = 1'b1;
         if (c == 11) s8n = 1'b0;
         chk("brk_low", {b8n, dn8n, t8n}, 3'b100);
         if (c < 49) cyc(1);
      end
      sb = 1'b0;
      cyc(1);
      for (int c = 0; c < 5; c++) begin
         chk("brk_release", {b8n, dn8n, t8n}, 3'b001);
         cyc(1);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
